conv_3x3_stream_ctrl: RTL and testbench
=======================================

# conv_3x3_stream_ctrl

Channel-sequencing controller for the 3x3 (dilated) convolution line-buffer datapath. It loads the weights for each input channel, then streams that channel's padded feature map from on-chip memory into the buffer at one pixel per cycle. It waits a fixed drain window, counts the window-valid outputs, clears the buffer, and advances to the next channel. It sits between the feature-map RAM, the weight loader and the buffer, under the layer-level controller's `start`/`done` handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel width
- IMAGE_WIDTH, 14, padded row width in pixels
- IMAGE_SIZE, 196, padded pixels per channel
- NUM_CHANNEL, 16, channels per layer pass
- FLUSH_CYCLES, 64, drain window after the last pixel; must cover buffer latency
- ADDR_WIDTH, 12, RAM address width; must satisfy 2^ADDR_WIDTH >= NUM_CHANNEL*IMAGE_SIZE
- CH_WIDTH, 5, channel index width; must satisfy 2^CH_WIDTH > NUM_CHANNEL
- CNT_WIDTH, 16, output-count width

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a layer pass
- stride2  in  1  stride mode; sampled only on an accepted start
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_WIDTH  RAM read address
- rd_data  in  DATA_WIDTH  RAM data; valid exactly 1 cycle after rd_en
- buf_valid_in  out  1  pixel strobe to the buffer
- buf_in  out  DATA_WIDTH  pixel to the buffer (rd_data passthrough)
- buf_stride2  out  1  latched stride mode
- buf_clear  out  1  one-cycle synchronous clear to the buffer (ORed with reset at the top level)
- buf_valid_out  in  1  buffer window-valid
- wgt_req  out  1  weight-load request for wgt_ch
- wgt_ch  out  CH_WIDTH  channel index
- wgt_ack  in  1  weights loaded; may arrive any number of cycles after wgt_req
- busy  out  1  high from an accepted start until done
- ch_done  out  1  one-cycle pulse per finished channel
- ch_out_count  out  CNT_WIDTH  buf_valid_out count for the finished channel; valid when ch_done is high
- done  out  1  one-cycle pulse after the last channel

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, NEXT.
- IDLE:
  - On start, latch stride2 into buf_stride2.
  - Clear ch_idx and pix_idx.
  - Go to LOAD_W.
- start is ignored in every state except IDLE.
- LOAD_W:
  - Hold wgt_req=1 with wgt_ch=ch_idx.
  - Go to STREAM on the cycle wgt_ack is sampled high; wgt_req drops that same edge.
- STREAM:
  - Assert rd_en every cycle with rd_addr = ch_idx*IMAGE_SIZE + pix_idx, then increment pix_idx.
  - After the rd_en for pix_idx = IMAGE_SIZE-1, go to DRAIN and reset pix_idx.
  - Exactly IMAGE_SIZE reads per channel, with no bubbles.
- DRAIN:
  - Last exactly FLUSH_CYCLES cycles, tracked by a drain counter.
  - Go to NEXT when the counter reaches FLUSH_CYCLES-1.
- NEXT (one cycle):
  - Pulse buf_clear and ch_done.
  - Present ch_out_count.
  - If ch_idx = NUM_CHANNEL-1: pulse done and go to IDLE.
  - Otherwise: increment ch_idx and go to LOAD_W.
- Output counter:
  - Clears on entry to LOAD_W.
  - Increments on every buf_valid_out sampled high in STREAM or DRAIN.
  - Saturates at all-ones.
- buf_valid_in is a 1-cycle delayed copy of rd_en; buf_in = rd_data.
- Arithmetic is unsigned. rd_addr is computed by an incrementing base register (base += IMAGE_SIZE on NEXT), not a multiplier.

## Timing
- Reset values:
  - rd_en, buf_valid_in, buf_clear, wgt_req, ch_done, done, busy = 0.
  - rd_addr, wgt_ch, ch_out_count, buf_stride2 = 0.
  - State = IDLE.
- Reset mid-operation:
  - Return to IDLE the next edge, with no done and no ch_done.
  - buf_valid_in drops the cycle after reset is sampled.
- start-to-first-rd_en latency:
  - start at edge T: wgt_req is high from T+1.
  - wgt_ack sampled at edge A: first rd_en is high from A+1.
- Per channel, from the first rd_en to ch_done: IMAGE_SIZE + FLUSH_CYCLES cycles.
- done coincides with the final ch_done; busy falls the following cycle.
- wgt_ack seen outside LOAD_W is ignored.
- A buf_valid_out seen in the NEXT cycle is not counted.

## Test plan
- IMAGE_WIDTH=4, IMAGE_SIZE=16, NUM_CHANNEL=2, FLUSH_CYCLES=8, wgt_ack one cycle after wgt_req, stride2=0:
  - rd_addr runs 0..15, then 16..31.
  - Two ch_done pulses, with done on the second.
  - busy is high for 2*(2+16+8+1)-ish cycles; check against the exact count per the timing rules.
- Same configuration with the buffer model attached, stride2=0 vs stride2=1:
  - ch_out_count equals the model's window count; the stride2 count is about a quarter of the stride1 count.
  - buf_stride2 is held for the whole pass.
- wgt_ack delayed 20 cycles for channel 1:
  - wgt_req is held for 20 cycles.
  - No rd_en until ack.
  - Streaming is bubble-free afterwards.
- start pulsed mid-STREAM, and stride2 toggled mid-pass:
  - No restart; addresses stay continuous.
  - buf_stride2 is unchanged.
- reset asserted at pix_idx=7 of channel 0:
  - All outputs return to reset values next cycle; no done.
  - A fresh start then begins at rd_addr=0.
- start on the cycle after done:
  - Accepted; second pass is identical to the first.
  - buf_clear pulsed exactly once per channel.

Source files
------------

// File: rtl/conv_3x3_stream_ctrl.sv
// Channel sequencer for the 3x3 line-buffer datapath: loads weights, streams one
// padded feature map per channel, drains, reports the window count and clears.
module conv_3x3_stream_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IMAGE_WIDTH  = 14,
    parameter int unsigned IMAGE_SIZE   = 196,
    parameter int unsigned NUM_CHANNEL  = 16,
    parameter int unsigned FLUSH_CYCLES = 64,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned CH_WIDTH     = 5,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  buf_valid_in,
    output logic [DATA_WIDTH-1:0] buf_in,
    output logic                  buf_stride2,
    output logic                  buf_clear,
    input  logic                  buf_valid_out,
    output logic                  wgt_req,
    output logic [CH_WIDTH-1:0]   wgt_ch,
    input  logic                  wgt_ack,
    output logic                  busy,
    output logic                  ch_done,
    output logic [CNT_WIDTH-1:0]  ch_out_count,
    output logic                  done
);

    localparam int unsigned PIX_W = $clog2(IMAGE_SIZE + 1);
    localparam int unsigned DRN_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [PIX_W-1:0]      PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [DRN_W-1:0]      DRN_LAST = DRN_W'(FLUSH_CYCLES - 1);
    localparam logic [CH_WIDTH-1:0]   CH_LAST  = CH_WIDTH'(NUM_CHANNEL - 1);
    localparam logic [ADDR_WIDTH-1:0] CH_STEP  = ADDR_WIDTH'(IMAGE_SIZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;

    // A channel must be a whole number of padded rows.
    if ((IMAGE_SIZE % IMAGE_WIDTH) != 0) begin : g_bad_geometry
        $error("IMAGE_SIZE is not a multiple of IMAGE_WIDTH");
    end

    logic [2:0]            state_q, state_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [DRN_W-1:0]      drn_q, drn_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  stride_q, stride_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wgt_req_q, wgt_req_d;
    logic                  next_q, next_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  bvi_q;
    logic                  count_en;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        pix_d    = pix_q;
        drn_d    = drn_q;
        base_d   = base_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        stride_d = stride_q;
        count_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stride_d = stride2;
                    ch_d     = '0;
                    pix_d    = '0;
                    base_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (wgt_ack) begin
                    addr_d  = base_q;
                    pix_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                count_en = 1'b1;
                if (pix_q == PIX_LAST) begin
                    pix_d   = '0;
                    drn_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    pix_d  = pix_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                count_en = 1'b1;
                if (drn_q == DRN_LAST) begin
                    drn_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (ch_q == CH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    base_d  = base_q + CH_STEP;
                    cnt_d   = '0;
                    state_d = S_LOAD_W;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Window counter saturates rather than wrapping.
        if (count_en && buf_valid_out && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        rd_en_d   = (state_d == S_STREAM);
        wgt_req_d = (state_d == S_LOAD_W);
        next_d    = (state_d == S_NEXT);
        done_d    = (state_d == S_NEXT) && (ch_q == CH_LAST);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            pix_q     <= '0;
            drn_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            stride_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            wgt_req_q <= 1'b0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            bvi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pix_q     <= pix_d;
            drn_q     <= drn_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            stride_q  <= stride_d;
            rd_en_q   <= rd_en_d;
            wgt_req_q <= wgt_req_d;
            next_q    <= next_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            bvi_q     <= rd_en_q;
        end
    end

    // RAM data returns one cycle after the read, aligned with buf_valid_in.
    assign buf_in       = rd_data;
    assign rd_en        = rd_en_q;
    assign rd_addr      = addr_q;
    assign buf_valid_in = bvi_q;
    assign buf_stride2  = stride_q;
    assign buf_clear    = next_q;
    assign ch_done      = next_q;
    assign wgt_req      = wgt_req_q;
    assign wgt_ch       = ch_q;
    assign busy         = busy_q;
    assign ch_out_count = cnt_q;
    assign done         = done_q;

endmodule

// File: tb/tb_conv_3x3_stream_ctrl.sv
// Randomised bench for conv_3x3_stream_ctrl against a pass/channel timeline model.
module tb_conv_3x3_stream_ctrl;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int IS = 16;
    localparam int NC = 2;
    localparam int FL = 8;
    localparam int AW = 12;
    localparam int CW = 5;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset, start, stride2;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          buf_valid_in;
    logic [DW-1:0] buf_in;
    logic          buf_stride2, buf_clear, buf_valid_out;
    logic          wgt_req;
    logic [CW-1:0] wgt_ch;
    logic          wgt_ack;
    logic          busy, ch_done, done;
    logic [NW-1:0] ch_out_count;

    conv_3x3_stream_ctrl #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_SIZE(IS), .NUM_CHANNEL(NC),
        .FLUSH_CYCLES(FL), .ADDR_WIDTH(AW), .CH_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stride2(stride2),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .buf_valid_in(buf_valid_in), .buf_in(buf_in), .buf_stride2(buf_stride2),
        .buf_clear(buf_clear), .buf_valid_out(buf_valid_out),
        .wgt_req(wgt_req), .wgt_ch(wgt_ch), .wgt_ack(wgt_ack),
        .busy(busy), .ch_done(ch_done), .ch_out_count(ch_out_count), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [DW-1:0] ram_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    // Feature-map RAM: one-cycle read latency.
    always @(posedge clk) rd_data <= rd_en ? ram_word(int'(rd_addr)) : 32'hDEAD_BEEF;

    // Stimulus knobs shared with the weight-loader / buffer drivers.
    int lat0 = 2, lat1 = 2;
    bit noise = 0, bvo_all = 0, mid_en = 0;
    int req_cnt = 0;

    always begin
        int lat;
        @(posedge clk); #1;
        req_cnt = wgt_req ? req_cnt + 1 : 0;
        lat = (int'(wgt_ch) == 1) ? lat1 : lat0;
        wgt_ack = (wgt_req && req_cnt >= lat) ||
                  (!wgt_req && noise && $urandom_range(0, 3) == 0);
        buf_valid_out = bvo_all ? 1'b1 : 1'(($urandom_range(0, 2) != 0));
    end

    // Reference model: pass -> channel -> (weight wait, IS reads, FL drain, one report cycle).
    int cyc = 0, m_t0 = 0, m_ch = 0, m_cnt = 0;
    bit m_busy = 0, m_req = 0, m_act = 0, m_stride = 0;

    always @(posedge clk) begin
        int p_end;
        cyc++;
        if (reset) begin
            m_busy = 0; m_req = 0; m_act = 0; m_stride = 0; m_cnt = 0; m_ch = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_req = 1; m_act = 0; m_ch = 0; m_cnt = 0; m_stride = stride2;
            end
        end else if (m_req) begin
            if (wgt_ack) begin
                m_req = 0; m_act = 1; m_t0 = cyc;
            end
        end else if (m_act) begin
            p_end = cyc - 1 - m_t0;
            if (p_end < IS + FL) begin
                if (buf_valid_out && m_cnt < 65535) m_cnt++;
            end else begin
                m_act = 0; m_cnt = 0;
                if (m_ch == NC - 1) m_busy = 0;
                else begin m_ch++; m_req = 1; end
            end
        end
    end

    int n_busy = 0, n_cd = 0, n_done = 0, n_clr = 0, n_rd = 0;
    int req_run = 0, req_len_ch1 = 0, last_cnt = 0;

    always @(negedge clk) begin
        int p;
        bit e_rd, e_bvi, e_nxt;
        if (cyc > 0) begin
            p     = cyc - m_t0;
            e_rd  = m_act && p < IS;
            e_bvi = m_act && p >= 1 && p <= IS;
            e_nxt = m_act && p == IS + FL;
            chk("busy", busy, m_busy);
            chk("wgt_req", wgt_req, m_req);
            if (m_req) chk("wgt_ch", wgt_ch, m_ch);
            chk("rd_en", rd_en, e_rd);
            if (e_rd) chk("rd_addr", rd_addr, m_ch * IS + p);
            chk("buf_valid_in", buf_valid_in, e_bvi);
            if (e_bvi) chk("buf_in", buf_in, ram_word(m_ch * IS + p - 1));
            chk("buf_clear", buf_clear, e_nxt);
            chk("ch_done", ch_done, e_nxt);
            chk("done", done, e_nxt && m_ch == NC - 1);
            if (e_nxt) chk("ch_out_count", ch_out_count, m_cnt);
            chk("buf_stride2", buf_stride2, m_stride);
        end
        n_busy += int'(busy);
        n_cd   += int'(ch_done);
        n_done += int'(done);
        n_clr  += int'(buf_clear);
        n_rd   += int'(rd_en);
        if (ch_done) last_cnt = int'(ch_out_count);
        if (wgt_req) req_run++;
        else if (req_run > 0) begin
            if (int'(wgt_ch) == 1) req_len_ch1 = req_run;
            req_run = 0;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_buf_valid_in"}, buf_valid_in, 0);
        chk({tag, "_buf_clear"}, buf_clear, 0);
        chk({tag, "_wgt_req"}, wgt_req, 0);
        chk({tag, "_wgt_ch"}, wgt_ch, 0);
        chk({tag, "_ch_done"}, ch_done, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ch_out_count"}, ch_out_count, 0);
        chk({tag, "_buf_stride2"}, buf_stride2, 0);
    endtask

    // Called at posedge+1; start is sampled on the next edge.
    task automatic run_pass(input bit s, input int exp_busy, input string tag);
        int b0, c0, d0, k0, r0;
        bit seen;
        b0 = n_busy; c0 = n_cd; d0 = n_done; k0 = n_clr; r0 = n_rd;
        start = 1; stride2 = s;
        @(posedge clk); #1;
        start = 0;
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk); #1;
            seen = done;
            if (!seen && mid_en) begin
                start   = rd_en && (rd_addr == 12'd5);
                stride2 = 1'($urandom_range(0, 1));
            end
        end
        start = 0;
        chk({tag, "_done_seen"}, seen, 1);
        @(posedge clk); #1;
        chk({tag, "_busy_cycles"}, n_busy - b0, exp_busy);
        chk({tag, "_ch_done_pulses"}, n_cd - c0, NC);
        chk({tag, "_done_pulses"}, n_done - d0, 1);
        chk({tag, "_clear_pulses"}, n_clr - k0, NC);
        chk({tag, "_reads"}, n_rd - r0, NC * IS);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit hit;
        reset = 1; start = 0; stride2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        reset = 0;

        // Every buffer output valid: each channel counts all IS+FL cycles.
        bvo_all = 1;
        run_pass(0, 2 * (2 + IS + FL + 1), "pA");
        chk("pA_count_literal", last_cnt, IS + FL);
        bvo_all = 0;

        // Back-to-back start in the cycle after done.
        run_pass(1, 2 * (2 + IS + FL + 1), "pB");

        // Slow channel-1 weights, stray acks, restart attempt and stride toggling mid-pass.
        noise = 1; mid_en = 1; lat1 = 20;
        run_pass(0, (2 + IS + FL + 1) + (20 + IS + FL + 1), "pC");
        chk("pC_req_len_ch1", req_len_ch1, 20);
        mid_en = 0; lat1 = 2;

        // Reset at pixel 7 of channel 0.
        d0 = n_done;
        start = 1; stride2 = 1;
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            hit = rd_en && (rd_addr == 12'd7);
        end
        chk("rst_mid_reached", hit, 1);
        reset = 1;
        @(posedge clk); #1;
        check_reset_vals("rst_mid");
        reset = 0;
        @(posedge clk); #1;
        chk("rst_mid_no_done", n_done - d0, 0);
        run_pass(0, 2 * (2 + IS + FL + 1), "pD");

        for (int k = 0; k < 4; k++) begin
            bit s;
            lat0 = $urandom_range(1, 6);
            lat1 = $urandom_range(1, 6);
            s = 1'($urandom_range(0, 1));
            run_pass(s, (lat0 + IS + FL + 1) + (lat1 + IS + FL + 1), "pR");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
